// File: rtl/mux_4to1_pkg.sv
// Shared definitions for the 4-to-1 bit-vector multiplexer:
// lane count, select type and constants, and the lane selection function
// used by both the combinational and the registered output paths.
package mux_4to1_pkg;

    localparam int N_LANES    = 4;
    localparam int SEL_W      = 2;
    // Widest lane the selection function can carry; DATA_W must not exceed it.
    localparam int LANE_MAX_W = 64;

    typedef logic [SEL_W-1:0]              sel_t;
    typedef logic [LANE_MAX_W-1:0]         lane_t;
    typedef logic [N_LANES*LANE_MAX_W-1:0] bus_t;

    typedef enum logic [SEL_W-1:0] {
        SEL_L0 = 2'b00,
        SEL_L1 = 2'b01,
        SEL_L2 = 2'b10,
        SEL_L3 = 2'b11
    } sel_e;

    // Lanes are packed contiguously data_w bits apart, so the selected lane
    // sits in the low bits after shifting by sel lanes. The caller keeps the
    // low data_w bits. An unknown select yields all-X in simulation.
    function automatic lane_t lane_select(input bus_t bus, input sel_t sel, input int data_w);
        bus_t sh;
        case (sel)
            SEL_L0:  sh = bus;
            SEL_L1:  sh = bus >> data_w;
            SEL_L2:  sh = bus >> (2 * data_w);
            SEL_L3:  sh = bus >> (3 * data_w);
            default: sh = 'x;
        endcase
        return sh[LANE_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mux_4to1_lane_reg.sv
// DATA_W-wide capture register with asynchronous active-high reset to zero.
module mux_4to1_lane_reg #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    // Capture the selected lane each edge; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mux_4to1_bv.sv
// 4-to-1 bit-vector multiplexer: combinational output f = lane[sel], plus a
// registered copy f_q with the select echoed on sel_q in the same cycle.
// Optional feature macro: MUX_4TO1_ONEHOT_EN adds sel_oh, a registered
// one-hot decode of sel (reset value 4'b0001).
module mux_4to1_bv
    import mux_4to1_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_LANES*DATA_W-1:0] i,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         f,
    output logic [DATA_W-1:0]         f_q,
    output logic [SEL_W-1:0]          sel_q
`ifdef MUX_4TO1_ONEHOT_EN
    ,
    output logic [N_LANES-1:0]        sel_oh
`endif
);

    bus_t              bus_ext;
    lane_t             lane_sel;
    logic [DATA_W-1:0] lane_d;
    sel_t              sel_d;

    // Widen the input bus to the function's fixed width and pick the lane.
    always_comb begin
        bus_ext                        = '0;
        bus_ext[N_LANES*DATA_W-1:0]    = i;
        lane_sel                       = lane_select(bus_ext, sel, DATA_W);
        lane_d                         = lane_sel[DATA_W-1:0];
        sel_d                          = sel;
    end

    // Bits above the lane width are leftovers of the neighbouring lanes.
    if (DATA_W < LANE_MAX_W) begin : g_pad
        logic unused_lane_hi;
        assign unused_lane_hi = ^lane_sel[LANE_MAX_W-1:DATA_W];
    end

    assign f = lane_d;

    mux_4to1_lane_reg #(
        .DATA_W (DATA_W)
    ) u_lane_reg (
        .clk (clk),
        .rst (rst),
        .d_i (lane_d),
        .q_o (f_q)
    );

    // Echo the select alongside f_q so consumers see which lane it came from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= SEL_L0;
        end else begin
            sel_q <= sel_d;
        end
    end

`ifdef MUX_4TO1_ONEHOT_EN
    logic [N_LANES-1:0] sel_oh_d;

    // One-hot decode of the incoming select.
    always_comb begin
        sel_oh_d = '0;
        sel_oh_d = 4'b0001 << sel;
    end

    // Registered decode, updating on the same edge as sel_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_oh <= 4'b0001;
        end else begin
            sel_oh <= sel_oh_d;
        end
    end

`ifndef SYNTHESIS
    a_sel_oh_onehot : assert property (@(posedge clk) disable iff (rst) $onehot(sel_oh))
        else $error("sel_oh not one-hot: %b", sel_oh);
`endif
`endif

endmodule

// File: tb/tb_mux_4to1_bv.sv
// Testbench for mux_4to1_bv: a 1-bit-lane and an 8-bit-lane instance share
// clock and reset; each scenario task drives stimulus and checks against a
// lane-array reference model.
module tb_mux_4to1_bv;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i1;
    logic [1:0] sel1;
    logic       f1, fq1;
    logic [1:0] selq1;
    logic [31:0] i8;
    logic [1:0] sel8;
    logic [7:0] f8, fq8;
    logic [1:0] selq8;
`ifdef MUX_4TO1_ONEHOT_EN
    logic [3:0] oh1, oh8;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: lanes are held individually, the bus is built from them.
    logic       lanes1 [4];
    logic [7:0] lanes8 [4];

    always #5 clk = ~clk;

    mux_4to1_bv #(.DATA_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .i(i1), .sel(sel1), .f(f1), .f_q(fq1), .sel_q(selq1)
`ifdef MUX_4TO1_ONEHOT_EN
        , .sel_oh(oh1)
`endif
    );

    mux_4to1_bv #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .i(i8), .sel(sel8), .f(f8), .f_q(fq8), .sel_q(selq8)
`ifdef MUX_4TO1_ONEHOT_EN
        , .sel_oh(oh8)
`endif
    );

    task automatic drive1();
        i1 = {lanes1[3], lanes1[2], lanes1[1], lanes1[0]};
    endtask

    task automatic drive8();
        i8 = {lanes8[3], lanes8[2], lanes8[1], lanes8[0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i1 = '0; sel1 = 2'b00; i8 = '0; sel8 = 2'b00;
        #1;
        vectors++; if (fq1 !== 1'b0) begin miscompares++; $display("FAIL reset_fq1 got %b want 0", fq1); end
        vectors++; if (selq1 !== 2'b00) begin miscompares++; $display("FAIL reset_selq1 got %b want 00", selq1); end
        vectors++; if (fq8 !== 8'h00) begin miscompares++; $display("FAIL reset_fq8 got %h want 00", fq8); end
`ifdef MUX_4TO1_ONEHOT_EN
        vectors++; if (oh1 !== 4'b0001) begin miscompares++; $display("FAIL reset_oh got %b want 0001", oh1); end
`endif
        tick();
        vectors++; if (fq1 !== 1'b0 || selq1 !== 2'b00) begin miscompares++; $display("FAIL reset_hold got fq=%b sel=%b want 0/00", fq1, selq1); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lane_sweep();
        logic [3:0] exp_f;
        exp_f = 4'b1000;
        i1 = 4'b1000;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            sel1 = 2'(s);
            #1;
            vectors++; if (f1 !== exp_f[s]) begin miscompares++; $display("FAIL sweep_f sel=%0d got %b want %b", s, f1, exp_f[s]); end
            tick();
            vectors++; if (fq1 !== exp_f[s] || selq1 !== 2'(s)) begin miscompares++; $display("FAIL sweep_fq sel=%0d got %b/%b want %b/%b", s, fq1, selq1, exp_f[s], 2'(s)); end
        end
    endtask

    task automatic test_data_sweep();
        logic [3:0] tab_i   [7] = '{4'd4, 4'd2, 4'd7, 4'd6, 4'b1010, 4'b1010, 4'b1010};
        logic [1:0] tab_sel [7] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
        logic       tab_f   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            i1 = tab_i[n]; sel1 = tab_sel[n];
            #1;
            vectors++; if (f1 !== tab_f[n]) begin miscompares++; $display("FAIL data_f i=%b sel=%b got %b want %b", tab_i[n], tab_sel[n], f1, tab_f[n]); end
            tick();
            vectors++; if (fq1 !== tab_f[n]) begin miscompares++; $display("FAIL data_fq i=%b sel=%b got %b want %b", tab_i[n], tab_sel[n], fq1, tab_f[n]); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel1 = 2'b11; i1 = 4'b1000;
        tick();
        vectors++; if (fq1 !== 1'b1) begin miscompares++; $display("FAIL areset_pre got %b want 1", fq1); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (fq1 !== 1'b0 || selq1 !== 2'b00) begin miscompares++; $display("FAIL areset_now got fq=%b sel=%b want 0/00", fq1, selq1); end
        vectors++; if (f1 !== 1'b1) begin miscompares++; $display("FAIL areset_f_live got %b want 1", f1); end
`ifdef MUX_4TO1_ONEHOT_EN
        vectors++; if (oh1 !== 4'b0001) begin miscompares++; $display("FAIL areset_oh got %b want 0001", oh1); end
`endif
        tick();
        vectors++; if (fq1 !== 1'b0) begin miscompares++; $display("FAIL areset_hold got %b want 0", fq1); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++; if (fq1 !== 1'b1 || selq1 !== 2'b11) begin miscompares++; $display("FAIL areset_release got fq=%b sel=%b want 1/11", fq1, selq1); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        i1 = 4'b0001; sel1 = 2'b00;
        tick();
        @(negedge clk);
        #4;
        i1 = 4'b0100; sel1 = 2'b10;
        tick();
        vectors++; if (fq1 !== 1'b1 || selq1 !== 2'b10) begin miscompares++; $display("FAIL simult got fq=%b sel=%b want 1/10", fq1, selq1); end
    endtask

    task automatic test_wide();
        lanes8[0] = 8'hA1; lanes8[1] = 8'hB2; lanes8[2] = 8'hC3; lanes8[3] = 8'hD4;
        drive8();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            sel8 = 2'(s);
            #1;
            vectors++; if (f8 !== lanes8[s]) begin miscompares++; $display("FAIL wide_f sel=%0d got %h want %h", s, f8, lanes8[s]); end
            tick();
            vectors++; if (fq8 !== lanes8[s] || selq8 !== 2'(s)) begin miscompares++; $display("FAIL wide_fq sel=%0d got %h/%b want %h/%b", s, fq8, selq8, lanes8[s], 2'(s)); end
        end
    endtask

`ifdef MUX_4TO1_ONEHOT_EN
    task automatic test_onehot();
        @(negedge clk); sel1 = 2'b10;
        tick();
        vectors++; if (oh1 !== 4'b0100) begin miscompares++; $display("FAIL onehot_10 got %b want 0100", oh1); end
        @(negedge clk); sel1 = 2'b11;
        tick();
        vectors++; if (oh1 !== 4'b1000) begin miscompares++; $display("FAIL onehot_11 got %b want 1000", oh1); end
    endtask
`endif

    task automatic test_random();
        logic       exp1;
        logic [7:0] exp8;
        logic [1:0] s1, s8;
        logic       pulsed;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                lanes1[k] = 1'($urandom_range(0, 1));
                lanes8[k] = 8'($urandom);
            end
            s1 = 2'($urandom_range(0, 3));
            s8 = 2'($urandom_range(0, 3));
            drive1(); drive8();
            sel1 = s1; sel8 = s8;
            exp1 = lanes1[s1];
            exp8 = lanes8[s8];
            #1;
            vectors++; if (f1 !== exp1) begin miscompares++; $display("FAIL rand_f1 n=%0d got %b want %b", n, f1, exp1); end
            vectors++; if (f8 !== exp8) begin miscompares++; $display("FAIL rand_f8 n=%0d got %h want %h", n, f8, exp8); end
            pulsed = ($urandom_range(0, 15) == 0);
            if (pulsed) begin
                #1 rst = 1'b1;
                #1;
                vectors++; if (fq1 !== 1'b0 || fq8 !== 8'h00 || selq8 !== 2'b00) begin miscompares++; $display("FAIL rand_rst n=%0d got %b/%h/%b want 0/00/00", n, fq1, fq8, selq8); end
                rst = 1'b0;
            end
            tick();
            vectors++; if (fq1 !== exp1 || selq1 !== s1) begin miscompares++; $display("FAIL rand_fq1 n=%0d got %b/%b want %b/%b", n, fq1, selq1, exp1, s1); end
            vectors++; if (fq8 !== exp8 || selq8 !== s8) begin miscompares++; $display("FAIL rand_fq8 n=%0d got %h/%b want %h/%b", n, fq8, selq8, exp8, s8); end
`ifdef MUX_4TO1_ONEHOT_EN
            vectors++; if (oh8 !== (4'b0001 << s8)) begin miscompares++; $display("FAIL rand_oh n=%0d got %b want %b", n, oh8, 4'b0001 << s8); end
`endif
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lane_sweep();
        test_data_sweep();
        test_async_reset();
        test_simultaneous();
        test_wide();
`ifdef MUX_4TO1_ONEHOT_EN
        test_onehot();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
